// File: rtl/clk_en_ctrl.sv
// Programmable clock-enable scheduler: three single-cycle strobes plus a square-wave ACLK,
// each channel retuned at run time through a one-deep valid/ready configuration slot.
module clk_en_ctrl #(
    parameter int DIV_W        = 18,
    parameter int ACLK_DIV_RST = 50000,
    parameter int MCLK_DIV_RST = 1024,
    parameter int DISP_DIV_RST = 131072
) (
    input  logic             CLK100MHz,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             SYNC,
    input  logic             CFG_VALID,
    output logic             CFG_READY,
    input  logic [1:0]       CFG_SEL,
    input  logic [DIV_W-1:0] CFG_DIV,
    output logic             CFG_ERR,
    output logic             ACLK_EN,
    output logic             MCLK_EN,
    output logic             DISP_EN,
    output logic             ACLK
);

    localparam int NCH = 3;
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    logic [NCH-1:0][DIV_W-1:0] cnt_r;
    logic [NCH-1:0][DIV_W-1:0] div_r;
    logic [NCH-1:0]            en_r;
    logic                      aclk_r;
    logic                      cfg_err_r;
    logic                      pend_valid_r;
    logic [1:0]                pend_sel_r;
    logic [DIV_W-1:0]          pend_div_r;

    logic                      accept_s;
    logic                      req_bad_s;
    logic [NCH-1:0]            wrap_s;
    logic [NCH-1:0]            apply_s;

    // Power-on divisor for each channel index (0 audio, 1 master, 2 display).
    function automatic logic [DIV_W-1:0] rst_div(input int ch);
        logic [DIV_W-1:0] d;
        case (ch)
            0:       d = DIV_W'(ACLK_DIV_RST);
            1:       d = DIV_W'(MCLK_DIV_RST);
            2:       d = DIV_W'(DISP_DIV_RST);
            default: d = DIV_W'(ACLK_DIV_RST);
        endcase
        return d;
    endfunction

    // Handshake decode, per-channel wrap detection and pending-update apply conditions.
    always_comb begin
        accept_s  = 1'b0;
        req_bad_s = 1'b0;
        wrap_s    = '0;
        apply_s   = '0;
        accept_s  = CFG_VALID && CFG_READY;
        case (CFG_SEL)
            2'd0, 2'd1, 2'd2: req_bad_s = (CFG_DIV < DIV_MIN);
            default:          req_bad_s = 1'b1;
        endcase
        for (int i = 0; i < NCH; i++) begin
            wrap_s[i] = RUN && (cnt_r[i] == (div_r[i] - DIV_W'(1)));
            // A frozen channel has no period boundary to wait for, so it takes the update at once.
            if (pend_valid_r && (pend_sel_r == 2'(i))) begin
                apply_s[i] = SYNC || !RUN || wrap_s[i];
            end else begin
                apply_s[i] = 1'b0;
            end
        end
    end

    // Channel counters, strobes, ACLK, error pulse and the single pending slot.
    always_ff @(posedge CLK100MHz) begin
        if (RESET) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= DIV_W'(0);
                div_r[i] <= rst_div(i);
            end
            en_r         <= '0;
            aclk_r       <= 1'b0;
            cfg_err_r    <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_sel_r   <= 2'd0;
            pend_div_r   <= DIV_W'(0);
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (SYNC) begin
                    cnt_r[i] <= DIV_W'(0);
                    en_r[i]  <= 1'b0;
                end else if (!RUN) begin
                    en_r[i] <= 1'b0;
                    if (apply_s[i]) begin
                        cnt_r[i] <= DIV_W'(0);
                    end
                end else if (wrap_s[i]) begin
                    cnt_r[i] <= DIV_W'(0);
                    en_r[i]  <= 1'b1;
                end else begin
                    cnt_r[i] <= cnt_r[i] + DIV_W'(1);
                    en_r[i]  <= 1'b0;
                end
                if (apply_s[i]) begin
                    div_r[i] <= pend_div_r;
                end
            end
            // ACLK flips together with the audio strobe, so a suppressed strobe leaves it alone.
            if (!SYNC && wrap_s[0]) begin
                aclk_r <= ~aclk_r;
            end
            cfg_err_r <= accept_s && req_bad_s;
            if (|apply_s) begin
                pend_valid_r <= 1'b0;
            end else if (accept_s && !req_bad_s) begin
                pend_valid_r <= 1'b1;
                pend_sel_r   <= CFG_SEL;
                pend_div_r   <= CFG_DIV;
            end
        end
    end

    assign CFG_READY = !RESET && !pend_valid_r;
    assign CFG_ERR   = cfg_err_r;
    assign ACLK_EN   = en_r[0];
    assign MCLK_EN   = en_r[1];
    assign DISP_EN   = en_r[2];
    assign ACLK      = aclk_r;

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Directed bench for clk_en_ctrl: default-divisor run, mid-period retune, a per-cycle
// vector table around SYNC/reject/RUN=0 configuration, and a ten-cycle RUN freeze.
module tb_clk_en_ctrl;

    localparam int DIV_W = 18;
    localparam int NVEC  = 25;

    logic             CLK100MHz = 1'b0;
    logic             RESET;
    logic             RUN;
    logic             SYNC;
    logic             CFG_VALID;
    logic             CFG_READY;
    logic [1:0]       CFG_SEL;
    logic [DIV_W-1:0] CFG_DIV;
    logic             CFG_ERR;
    logic             ACLK_EN;
    logic             MCLK_EN;
    logic             DISP_EN;
    logic             ACLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic             run;
        logic             sync;
        logic             valid;
        logic [1:0]       sel;
        logic [DIV_W-1:0] div;
        logic             ready;
        logic             err;
        logic             aen;
        logic             men;
        logic             den;
        logic             aclk;
    } vec_t;

    vec_t vecs [NVEC];
    int   nvec = 0;

    clk_en_ctrl dut (
        .CLK100MHz (CLK100MHz),
        .RESET     (RESET),
        .RUN       (RUN),
        .SYNC      (SYNC),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .CFG_SEL   (CFG_SEL),
        .CFG_DIV   (CFG_DIV),
        .CFG_ERR   (CFG_ERR),
        .ACLK_EN   (ACLK_EN),
        .MCLK_EN   (MCLK_EN),
        .DISP_EN   (DISP_EN),
        .ACLK      (ACLK)
    );

    always #5 CLK100MHz = ~CLK100MHz;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK100MHz);
        #1;
        cyc++;
    endtask

    task automatic add_vec(input logic run, input logic sync, input logic valid,
                           input logic [1:0] sel, input logic [DIV_W-1:0] div,
                           input logic ready, input logic err, input logic aen,
                           input logic men, input logic den, input logic aclk);
        vecs[nvec] = '{run, sync, valid, sel, div, ready, err, aen, men, den, aclk};
        nvec++;
    endtask

    initial begin
        int m_first, m_last, m_count, m_gap_err, a_first, a_count, d_count, e_count;
        int ready_bad, m_early, other_bad, freeze_en, freeze_aclk;

        // Rows cover cycles 1041..1065 after the second reset: run sync valid sel div | ready err aen men den aclk
        add_vec(1'b1, 1'b0, 1'b1, 2'd2, 18'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // 1041 queue disp div 8
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 2'd0, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 1044 SYNC on mclk wrap
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 1045 strobe suppressed
        add_vec(1'b1, 1'b0, 1'b1, 2'd3, 18'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // reserved sel
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b1, 2'd0, 18'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // divisor 1
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // 1053 disp 8 after SYNC
        add_vec(1'b0, 1'b0, 1'b1, 2'd0, 18'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 1054 audio div 3, RUN=0
        add_vec(1'b0, 1'b0, 1'b0, 2'd0, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 1056 applied
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); // 1059
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 1062
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 18'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 1065

        RESET = 1'b1; RUN = 1'b1; SYNC = 1'b0; CFG_VALID = 1'b0; CFG_SEL = 2'd0; CFG_DIV = 18'd0;
        repeat (3) @(posedge CLK100MHz);
        #1;
        chk("rst_ready", CFG_READY, 1'b0);
        chk("rst_strobes", ACLK_EN | MCLK_EN | DISP_EN, 1'b0);
        chk("rst_aclk", ACLK, 1'b0);
        chk("rst_err", CFG_ERR, 1'b0);
        RESET = 1'b0;
        #1;
        cyc = 1;
        chk("ready_release", CFG_READY, 1'b1);

        // Default divisors; a display update is queued and then discarded by a reset on an mclk wrap.
        m_first = 0; m_last = 0; m_count = 0; m_gap_err = 0;
        a_first = 0; a_count = 0; d_count = 0; e_count = 0;
        for (int c = 1; c <= 50176; c++) begin
            if (c > 1) step();
            CFG_VALID = (c == 50002);
            CFG_SEL   = 2'd2;
            CFG_DIV   = 18'd8;
            if (c == 50176) RESET = 1'b1;
            #1;
            if (MCLK_EN) begin
                if (m_count == 0) m_first = c;
                else if (c - m_last != 1024) m_gap_err++;
                m_last = c;
                m_count++;
            end
            if (ACLK_EN) begin
                if (a_count == 0) a_first = c;
                a_count++;
            end
            if (DISP_EN) d_count++;
            if (CFG_ERR) e_count++;
            if (c == 50000) chk("aclk_before_toggle", ACLK, 1'b0);
            if (c == 50001) chk("aclk_first_toggle", ACLK, 1'b1);
            if (c == 50002) chk("ready_before_disp_cfg", CFG_READY, 1'b1);
            if (c == 50003) chk("ready_disp_pending", CFG_READY, 1'b0);
            if (c == 50175) chk("ready_still_pending", CFG_READY, 1'b0);
        end
        chki("mclk_first", m_first, 1025);
        chki("mclk_count", m_count, 48);
        chki("mclk_gap_errs", m_gap_err, 0);
        chki("aclk_en_first", a_first, 50001);
        chki("aclk_en_count", a_count, 1);
        chki("disp_en_count_default", d_count, 0);
        chki("cfg_err_count_default", e_count, 0);

        step();
        chk("no_strobe_after_reset", MCLK_EN, 1'b0);
        chk("aclk_cleared_by_reset", ACLK, 1'b0);
        chk("ready_in_reset", CFG_READY, 1'b0);
        RESET = 1'b0;
        #1;
        cyc = 1;
        chk("ready_pending_dropped", CFG_READY, 1'b1);

        // Retune master to 4 mid-period: the 1024 period finishes first.
        ready_bad = 0; m_early = 0; other_bad = 0;
        for (int c = 1; c <= 1040; c++) begin
            if (c > 1) step();
            CFG_VALID = (c == 100);
            CFG_SEL   = 2'd1;
            CFG_DIV   = 18'd4;
            #1;
            if (c == 100) chk("ready_at_mclk_cfg", CFG_READY, 1'b1);
            if (c == 101) chk("ready_low_after_hs", CFG_READY, 1'b0);
            if (c >= 101 && c <= 1024 && CFG_READY) ready_bad++;
            if (c <= 1024 && MCLK_EN) m_early++;
            if (c == 1025) chk("ready_after_apply", CFG_READY, 1'b1);
            if (c >= 1020) chk("mclk_en_div4", MCLK_EN, (c >= 1025) && ((c - 1025) % 4 == 0));
            if (DISP_EN || ACLK_EN || ACLK || CFG_ERR) other_bad++;
        end
        CFG_VALID = 1'b0;
        chki("ready_high_while_pending", ready_bad, 0);
        chki("mclk_early_strobes", m_early, 0);
        chki("other_outputs_active", other_bad, 0);

        // Per-cycle vector table.
        for (int i = 0; i < NVEC; i++) begin
            step();
            RUN       = vecs[i].run;
            SYNC      = vecs[i].sync;
            CFG_VALID = vecs[i].valid;
            CFG_SEL   = vecs[i].sel;
            CFG_DIV   = vecs[i].div;
            #1;
            chk("tbl_ready", CFG_READY, vecs[i].ready);
            chk("tbl_err", CFG_ERR, vecs[i].err);
            chk("tbl_aclk_en", ACLK_EN, vecs[i].aen);
            chk("tbl_mclk_en", MCLK_EN, vecs[i].men);
            chk("tbl_disp_en", DISP_EN, vecs[i].den);
            chk("tbl_aclk", ACLK, vecs[i].aclk);
        end
        RUN = 1'b1; SYNC = 1'b0; CFG_VALID = 1'b0;

        // RUN low for cycles 1066..1075: every strobe moves exactly 10 cycles later.
        freeze_en = 0; freeze_aclk = 0;
        for (int c = 1066; c <= 1081; c++) begin
            step();
            RUN = (c < 1066) || (c > 1075);
            #1;
            if (c <= 1076) begin
                if (ACLK_EN || MCLK_EN || DISP_EN) freeze_en++;
                if (ACLK != 1'b1) freeze_aclk++;
            end
            if (c == 1077) chk("mclk_after_freeze", MCLK_EN, 1'b1);
            if (c == 1077) chk("aclk_en_not_yet", ACLK_EN, 1'b0);
            if (c == 1078) chk("aclk_en_after_freeze", ACLK_EN, 1'b1);
            if (c == 1078) chk("aclk_toggle_after_freeze", ACLK, 1'b0);
            if (c == 1080) chk("disp_not_yet", DISP_EN, 1'b0);
            if (c == 1081) chk("disp_after_freeze", DISP_EN, 1'b1);
        end
        chki("strobes_during_freeze", freeze_en, 0);
        chki("aclk_not_held", freeze_aclk, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
